// File: rtl/uart_word_rx_if.sv
// uart_word_rx_if: valid/ready word stream carrying assembled UART words
interface uart_word_rx_if;
  logic [31:0] data_out;
  logic        data_valid;
  logic        data_ready;
  modport master(output data_out, data_valid, input data_ready);
  modport slave(input data_out, data_valid, output data_ready);
endinterface

// File: rtl/uart_word_rx.sv
// uart_word_rx: 8N1 UART receiver packing four bytes LSB-first into 32-bit words
module uart_word_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           uart_rx,
  uart_word_rx_if.master wr,
  output logic           error_flag,
  output logic [1:0]     error_code,
  input  logic           err_clear
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int TW = $clog2(TIMEOUT_BITS * CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_BITS * CLKS_PER_BIT);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t        state, state_d;
  logic          rx_m, rx_s;
  logic [CW-1:0] cnt, cnt_d;
  logic [2:0]    bit_n, bit_d;
  logic [7:0]    sh, sh_d;
  logic [1:0]    idx, idx_d;
  logic [23:0]   part, part_d;
  logic [TW-1:0] idle, idle_d;
  logic [31:0]   word_d;
  logic          valid_d;
  logic [1:0]    fault;
  logic          tick;
  assign tick = cnt == (state == START ? HALF : LAST);
  always_comb begin
    state_d = state;
    cnt_d   = tick ? '0 : cnt + CW'(1);
    bit_d   = bit_n;
    sh_d    = sh;
    idx_d   = idx;
    part_d  = part;
    idle_d  = '0;
    word_d  = wr.data_out;
    valid_d = wr.data_valid && !wr.data_ready;
    fault   = 2'b00;
    case (state)
      IDLE: begin
        cnt_d   = '0;
        state_d = rx_s ? IDLE : START;
        idle_d  = (rx_s && idx != 2'd0) ? idle + TW'(1) : '0;
        if (idle_d == TLIM) begin
          idle_d = '0;
          idx_d  = '0;
          fault  = 2'b11;
        end
      end
      START: if (tick) begin
        state_d = rx_s ? IDLE : DATA;
        bit_d   = '0;
      end
      DATA: if (tick) begin
        sh_d  = {rx_s, sh[7:1]};
        bit_d = bit_n + 3'd1;
        if (bit_n == 3'd7) state_d = STOP;
      end
      STOP: if (tick) begin
        state_d = IDLE;
        idx_d   = idx + 2'd1;
        if (!rx_s) begin
          idx_d = '0;
          fault = 2'b01;
        end else if (idx == 2'd3) begin
          if (wr.data_valid && !wr.data_ready) fault = 2'b10;
          else begin
            word_d  = {sh, part};
            valid_d = 1'b1;
          end
        end else part_d[{idx, 3'b000} +: 8] = sh;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_m          <= 1'b1;
      rx_s          <= 1'b1;
      state         <= IDLE;
      cnt           <= '0;
      bit_n         <= '0;
      sh            <= '0;
      idx           <= '0;
      part          <= '0;
      idle          <= '0;
      wr.data_out   <= '0;
      wr.data_valid <= 1'b0;
      error_flag    <= 1'b0;
      error_code    <= 2'b00;
    end else begin
      rx_m          <= uart_rx;
      rx_s          <= rx_m;
      state         <= state_d;
      cnt           <= cnt_d;
      bit_n         <= bit_d;
      sh            <= sh_d;
      idx           <= idx_d;
      part          <= part_d;
      idle          <= idle_d;
      wr.data_out   <= word_d;
      wr.data_valid <= valid_d;
      error_flag    <= fault != 2'b00 || (error_flag && !err_clear);
      error_code    <= fault != 2'b00 ? fault : err_clear ? 2'b00 : error_code;
    end
  end
endmodule

// File: tb/tb_uart_word_rx.sv
// tb_uart_word_rx: self-checking bench for uart_word_rx
module tb_uart_word_rx;
  localparam int CPB  = 16;
  localparam int TB   = 20;
  localparam int TLIM = CPB * TB;
  typedef struct {
    int          n;
    logic [39:0] b;
    logic [4:0]  bad;
    logic        has_word;
    logic [31:0] word;
    logic [1:0]  code;
  } vec_t;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        uart_rx = 1'b1;
  logic        err_clear = 1'b0;
  logic        error_flag;
  logic [1:0]  error_code;
  logic [1:0]  mode = 2'd1;
  int          total = 0;
  int          passed = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  part_q[$];
  vec_t        vecs[7];
  uart_word_rx_if bus();
  uart_word_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TB)) dut (
    .clk(clk), .reset(reset), .uart_rx(uart_rx), .wr(bus),
    .error_flag(error_flag), .error_code(error_code), .err_clear(err_clear)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    #1;
    bus.data_ready = (mode == 2'd2) ? 1'($urandom_range(0, 1)) : (mode == 2'd1);
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s got=%h required=%h", name, act, exp);
  endtask
  always @(negedge clk)
    if (bus.data_valid === 1'b1 && bus.data_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_word got=%h required=no word", bus.data_out);
      end else check("word", bus.data_out, exp_q.pop_front());
    end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    if (n > 0) #1;
  endtask
  task automatic send_byte(input logic [7:0] b, input logic bad);
    logic [9:0] f;
    f = {~bad, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = f[i];
      tick((i == 9 && bad) ? CPB / 2 + 3 : CPB);
    end
    uart_rx = 1'b1;
  endtask
  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 1'b0);
  endtask
  task automatic clear_err();
    err_clear = 1'b1;
    tick(1);
    err_clear = 1'b0;
    tick(2);
  endtask
  initial begin
    logic [7:0] rb;
    logic       rbad;
    logic [1:0] last;
    vecs[0] = '{4, 40'h0012345678, 5'b00000, 1'b1, 32'h12345678, 2'd0};
    vecs[1] = '{5, 40'hEFBEADDEA5, 5'b00001, 1'b1, 32'hEFBEADDE, 2'd1};
    vecs[2] = '{4, 40'h00A5A5A5A5, 5'b00001, 1'b0, 32'h0, 2'd3};
    vecs[3] = '{4, 40'h00FF00FF00, 5'b01000, 1'b0, 32'h0, 2'd1};
    vecs[4] = '{4, 40'h0001020304, 5'b00010, 1'b0, 32'h0, 2'd3};
    vecs[5] = '{4, 40'h00DEADBEEF, 5'b00000, 1'b1, 32'hDEADBEEF, 2'd0};
    vecs[6] = '{5, 40'h99DEADBEEF, 5'b00000, 1'b1, 32'hDEADBEEF, 2'd3};
    tick(3);
    check("rst_data", bus.data_out, 32'h0);
    check("rst_valid", 32'(bus.data_valid), 32'd0);
    check("rst_flag", 32'(error_flag), 32'd0);
    check("rst_code", 32'(error_code), 32'd0);
    reset = 1'b0;
    tick(5);
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].has_word) exp_q.push_back(vecs[i].word);
      for (int k = 0; k < vecs[i].n; k++) send_byte(vecs[i].b[8*k +: 8], vecs[i].bad[k]);
      tick(TLIM + 100);
      check($sformatf("row%0d_pending", i), 32'(exp_q.size()), 32'd0);
      check($sformatf("row%0d_code", i), 32'(error_code), 32'(vecs[i].code));
      check($sformatf("row%0d_flag", i), 32'(error_flag), 32'(vecs[i].code != 2'd0));
      clear_err();
      check($sformatf("row%0d_clr_flag", i), 32'(error_flag), 32'd0);
      check($sformatf("row%0d_clr_code", i), 32'(error_code), 32'd0);
    end
    mode = 2'd0;
    tick(2);
    exp_q.push_back(32'h11223344);
    send_word(32'h11223344);
    send_word(32'h55667788);
    tick(20);
    check("ovr_valid", 32'(bus.data_valid), 32'd1);
    check("ovr_held", bus.data_out, 32'h11223344);
    check("ovr_code", 32'(error_code), 32'd2);
    check("ovr_flag", 32'(error_flag), 32'd1);
    mode = 2'd1;
    tick(10);
    check("ovr_pending", 32'(exp_q.size()), 32'd0);
    check("ovr_drained", 32'(bus.data_valid), 32'd0);
    clear_err();
    send_byte(8'h34, 1'b0);
    send_byte(8'h12, 1'b0);
    tick(TLIM - 40);
    check("to_early_code", 32'(error_code), 32'd0);
    tick(100);
    check("to_code", 32'(error_code), 32'd3);
    check("to_flag", 32'(error_flag), 32'd1);
    clear_err();
    exp_q.push_back(32'hCAFEF00D);
    send_word(32'hCAFEF00D);
    tick(20);
    check("to_fresh_word", 32'(exp_q.size()), 32'd0);
    uart_rx = 1'b0;
    tick(4);
    uart_rx = 1'b1;
    tick(100);
    check("glitch_flag", 32'(error_flag), 32'd0);
    check("glitch_valid", 32'(bus.data_valid), 32'd0);
    exp_q.push_back(32'h0BADCAFE);
    send_word(32'h0BADCAFE);
    tick(20);
    check("glitch_word", 32'(exp_q.size()), 32'd0);
    send_byte(8'h5A, 1'b1);
    tick(4);
    check("pre_rst_code", 32'(error_code), 32'd1);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    uart_rx = 1'b0;
    tick(CPB);
    uart_rx = 1'b1;
    tick(CPB);
    uart_rx = 1'b0;
    tick(CPB);
    reset = 1'b1;
    tick(1);
    check("mid_rst_data", bus.data_out, 32'h0);
    check("mid_rst_valid", 32'(bus.data_valid), 32'd0);
    check("mid_rst_flag", 32'(error_flag), 32'd0);
    check("mid_rst_code", 32'(error_code), 32'd0);
    uart_rx = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(3 * CPB);
    exp_q.push_back(32'h87654321);
    send_word(32'h87654321);
    tick(20);
    check("post_rst_word", 32'(exp_q.size()), 32'd0);
    check("post_rst_flag", 32'(error_flag), 32'd0);
    mode = 2'd2;
    clear_err();
    last = 2'd0;
    for (int i = 0; i < 48; i++) begin
      rb = 8'($urandom);
      rbad = $urandom_range(0, 7) == 0;
      if (rbad) begin
        part_q.delete();
        last = 2'd1;
      end else begin
        part_q.push_back(rb);
        if (part_q.size() == 4) begin
          exp_q.push_back({part_q[3], part_q[2], part_q[1], part_q[0]});
          part_q.delete();
        end
      end
      send_byte(rb, rbad);
      tick($urandom_range(0, 40));
    end
    mode = 2'd1;
    tick(TLIM + 100);
    if (part_q.size() != 0) last = 2'd3;
    check("rand_pending", 32'(exp_q.size()), 32'd0);
    check("rand_code", 32'(error_code), 32'(last));
    check("rand_flag", 32'(error_flag), 32'(last != 2'd0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
